// File: rtl/fetch_queue_if.sv
// Issue-side and instruction-memory signals of the dual-issue fetch queue.
// master = the queue itself, slave = the memory/core environment around it.
interface fetch_queue_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] inst1;
   logic [31:0] inst2;
   logic        valid1;
   logic        valid2;
   logic [31:0] pc1;
   logic [1:0]  pop_cnt;
   logic        redirect;
   logic [31:0] redirect_pc;

   modport master (
      output imem_req, imem_addr, inst1, inst2, valid1, valid2, pc1,
      input  imem_rdata, pop_cnt, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, inst1, inst2, valid1, valid2, pc1,
      output imem_rdata, pop_cnt, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// Dual-issue prefetch queue: streams sequential words from a 1-cycle imem into a circular buffer.
// Optional FETCHQ_PERF_EN adds perf_empty_cycles / perf_redirects counters.
module fetch_queue #(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic               clk,
   input  logic               reset,
   fetch_queue_if.master      bus
`ifdef FETCHQ_PERF_EN
   ,
   output logic [31:0]        perf_empty_cycles,
   output logic [31:0]        perf_redirects
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

   logic [31:0]   mem_q [DEPTH];
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   head_pc_q, head_pc_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pending_q, pending_d;
   logic          drop_q, drop_d;

   logic          req_s;
   logic          push_s;
   logic          mem_we_s;
   logic [1:0]    pop_req_s;
   logic [1:0]    eff_pop_s;
   logic [31:0]   redir_pc_s;

   // Credit check, pop clamping and next-state computation
   always_comb begin
      pop_req_s  = (bus.pop_cnt == 2'd3) ? 2'd2 : bus.pop_cnt;
      if (CW'(pop_req_s) > count_q) begin
         eff_pop_s = count_q[1:0];
      end else begin
         eff_pop_s = pop_req_s;
      end
      // In-flight requests hold a slot so a returning word always has room
      req_s      = !reset && !bus.redirect &&
                   (((CW+1)'(count_q) + (CW+1)'(pending_q)) < DEPTH_V);
      push_s     = pending_q && !drop_q;
      redir_pc_s = {bus.redirect_pc[31:2], 2'b00};

      fetch_pc_d = fetch_pc_q;
      head_pc_d  = head_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      pending_d  = 1'b0;
      drop_d     = 1'b0;
      mem_we_s   = 1'b0;

      if (bus.redirect) begin
         count_d    = {CW{1'b0}};
         rd_ptr_d   = wr_ptr_q;
         fetch_pc_d = redir_pc_s;
         head_pc_d  = redir_pc_s;
         drop_d     = pending_q;
      end else begin
         mem_we_s   = push_s;
         pending_d  = req_s;
         fetch_pc_d = req_s ? (fetch_pc_q + 32'd4) : fetch_pc_q;
         wr_ptr_d   = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
         rd_ptr_d   = rd_ptr_q + AW'(eff_pop_s);
         head_pc_d  = head_pc_q + {28'd0, eff_pop_s, 2'b00};
         count_d    = count_q + CW'(push_s) - CW'(eff_pop_s);
      end
   end

   // Queue control state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         head_pc_q  <= RESET_PC;
         rd_ptr_q   <= {AW{1'b0}};
         wr_ptr_q   <= {AW{1'b0}};
         count_q    <= {CW{1'b0}};
         pending_q  <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         head_pc_q  <= head_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         pending_q  <= pending_d;
         drop_q     <= drop_d;
      end
   end

   // Word storage; contents are meaningless until counted, so no reset
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[wr_ptr_q] <= bus.imem_rdata;
      end
   end

   // Issue pair and fetch request, derived from state only (plus redirect for the request)
   always_comb begin
      bus.imem_req  = req_s;
      bus.imem_addr = fetch_pc_q;
      bus.inst1     = mem_q[rd_ptr_q];
      bus.inst2     = mem_q[rd_ptr_q + AW'(1)];
      bus.valid1    = (count_q != {CW{1'b0}});
      bus.valid2    = (count_q >= CW'(2));
      bus.pc1       = head_pc_q;
   end

`ifdef FETCHQ_PERF_EN
   logic [31:0] perf_empty_q, perf_empty_d;
   logic [31:0] perf_redir_q, perf_redir_d;

   // Performance counter increments
   always_comb begin
      perf_empty_d = perf_empty_q + ((count_q == {CW{1'b0}}) ? 32'd1 : 32'd0);
      perf_redir_d = perf_redir_q + (bus.redirect ? 32'd1 : 32'd0);
   end

   // Performance counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_empty_q <= 32'd0;
         perf_redir_q <= 32'd0;
      end else begin
         perf_empty_q <= perf_empty_d;
         perf_redir_q <= perf_redir_d;
      end
   end

   assign perf_empty_cycles = perf_empty_q;
   assign perf_redirects    = perf_redir_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: imem returns word == address; a queue-of-PCs
// reference model predicts request, issue pair and (optionally) perf counters every cycle.
module tb_fetch_queue;
   localparam int          DEPTH    = 8;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic clk;
   logic reset;
   fetch_queue_if bus ();

`ifdef FETCHQ_PERF_EN
   logic [31:0] perf_empty_cycles;
   logic [31:0] perf_redirects;
`endif

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef FETCHQ_PERF_EN
      ,
      .perf_empty_cycles (perf_empty_cycles),
      .perf_redirects    (perf_redirects)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: buffered words as a list of PCs, one optional in-flight fetch
   logic [31:0] mq[$];
   logic        infl_v;
   logic [31:0] infl_a;
   logic [31:0] m_fetch;
   logic [31:0] m_head;
   logic [31:0] m_empty;
   logic [31:0] m_redirs;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      infl_v   = 1'b0;
      infl_a   = 32'h0;
      m_fetch  = RESET_PC;
      m_head   = RESET_PC;
      m_empty  = 32'd0;
      m_redirs = 32'd0;
   endtask

   // Called at posedge+1; applies inputs, checks, advances one clock and the model
   task automatic step(input logic [1:0] pop, input logic redir, input logic [31:0] rpc);
      logic        exp_req;
      logic        act_req;
      logic [31:0] act_addr;
      int          p;
      int          n;
      bus.pop_cnt     = pop;
      bus.redirect    = redir;
      bus.redirect_pc = rpc;
      #1;
      exp_req = !redir && ((mq.size() + (infl_v ? 1 : 0)) < DEPTH);
      check("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
      if (exp_req) check("imem_addr", bus.imem_addr, m_fetch);
      check("valid1", {31'd0, bus.valid1}, {31'd0, mq.size() >= 1});
      check("valid2", {31'd0, bus.valid2}, {31'd0, mq.size() >= 2});
      check("pc1", bus.pc1, m_head);
      if (mq.size() >= 1) check("inst1", bus.inst1, mq[0]);
      if (mq.size() >= 2) check("inst2", bus.inst2, mq[1]);
`ifdef FETCHQ_PERF_EN
      check("perf_empty", perf_empty_cycles, m_empty);
      check("perf_redirects", perf_redirects, m_redirs);
`endif
      act_req  = bus.imem_req;
      act_addr = bus.imem_addr;
      if (mq.size() == 0) m_empty++;
      @(posedge clk);
      if (redir) begin
         mq.delete();
         infl_v  = 1'b0;
         m_fetch = {rpc[31:2], 2'b00};
         m_head  = {rpc[31:2], 2'b00};
         m_redirs++;
      end else begin
         p = (pop == 2'd3) ? 2 : int'(pop);
         n = (p < mq.size()) ? p : mq.size();
         for (int i = 0; i < n; i++) void'(mq.pop_front());
         m_head = m_head + 32'(4 * n);
         if (infl_v) mq.push_back(infl_a);
         infl_v = exp_req;
         infl_a = m_fetch;
         if (exp_req) m_fetch = m_fetch + 32'd4;
      end
      #1;
      bus.imem_rdata = act_req ? act_addr : $urandom();
   endtask

   // Asynchronous reset pulse starting mid-cycle; returns at posedge+1 with reset low
   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      check("rst_valid1", {31'd0, bus.valid1}, 32'd0);
      check("rst_valid2", {31'd0, bus.valid2}, 32'd0);
      check("rst_pc1", bus.pc1, RESET_PC);
      check("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
`ifdef FETCHQ_PERF_EN
      check("rst_perf_empty", perf_empty_cycles, 32'd0);
      check("rst_perf_redirects", perf_redirects, 32'd0);
`endif
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset           = 1'b1;
      bus.pop_cnt     = 2'd0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.imem_rdata  = 32'h0;
      model_reset();
      @(posedge clk);
      #1;
      pulse_reset();

      // Fill to full with no pops; requests stop after DEPTH words
      for (int i = 0; i < 12; i++) step(2'd0, 1'b0, 32'h0);
      // Drain in pairs from full
      for (int i = 0; i < 4; i++) step(2'd2, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) step(2'd3, 1'b0, 32'h0);

      // Single buffered word with pop of two
      step(2'd0, 1'b1, 32'h40);
      step(2'd0, 1'b0, 32'h0);
      step(2'd0, 1'b0, 32'h0);
      step(2'd2, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) step(2'd2, 1'b0, 32'h0);

      // Redirect to 0x100 while the 0x14 fetch is in flight
      pulse_reset();
      for (int i = 0; i < 6; i++) step(2'd0, 1'b0, 32'h0);
      step(2'd0, 1'b1, 32'h100);
      for (int i = 0; i < 5; i++) step(2'd0, 1'b0, 32'h0);

      // Back-to-back redirects, last wins; low address bits ignored
      step(2'd1, 1'b1, 32'h200);
      step(2'd1, 1'b1, 32'h303);
      for (int i = 0; i < 6; i++) step(2'd1, 1'b0, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
              $urandom() & 32'h0000_0fff);
      end

      // Asynchronous reset mid-run, then resume
      step(2'd1, 1'b1, 32'h500);
      step(2'd0, 1'b0, 32'h0);
      pulse_reset();
      for (int i = 0; i < 10; i++) step(2'($urandom_range(0, 3)), 1'b0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
